// File: rtl/alarm_ringer.sv
// Alarm responder: drives the buzzer pattern, handles snooze/dismiss and ring
// timeout, and pulls the Alarm enable low to clear and re-arm its latch.
module alarm_ringer #(
    parameter int BEEP_HALF    = 25000000,
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SEC   = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_in,
    input  logic       sec_tick,
    input  logic       snooze_btn,
    input  logic       dismiss_btn,
    output logic       alarm_en_out,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [3:0] snooze_count
);
    localparam logic [25:0] BEEP_LAST   = 26'(BEEP_HALF - 1);
    localparam logic [7:0]  RING_LAST   = 8'(RING_TIMEOUT - 1);
    localparam logic [9:0]  SNOOZE_LOAD = 10'(SNOOZE_SEC);
    localparam logic [3:0]  SNOOZE_MAX  = 4'(MAX_SNOOZE);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE, REARM} state_t;

    state_t      state, state_nx;
    logic        prev_alarm, prev_snooze, prev_dismiss;
    logic        alarm_rise, snooze_rise, dismiss_rise;
    logic [7:0]  ring_sec, ring_sec_nx;
    logic [9:0]  snooze_tmr, snooze_tmr_nx;
    logic [25:0] beep_cnt, beep_cnt_nx;
    logic [3:0]  snooze_count_nx;
    logic        buzzer_nx;

    assign alarm_rise   = alarm_in & ~prev_alarm;
    assign snooze_rise  = snooze_btn & ~prev_snooze;
    assign dismiss_rise = dismiss_btn & ~prev_dismiss;

    assign alarm_en_out = (state != REARM);
    assign ringing      = (state == RING);
    assign snoozing     = (state == SNOOZE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            prev_alarm   <= 1'b0;
            prev_snooze  <= 1'b0;
            prev_dismiss <= 1'b0;
            ring_sec     <= '0;
            snooze_tmr   <= '0;
            beep_cnt     <= '0;
            snooze_count <= '0;
            buzzer       <= 1'b0;
        end else begin
            state        <= state_nx;
            prev_alarm   <= alarm_in;
            prev_snooze  <= snooze_btn;
            prev_dismiss <= dismiss_btn;
            ring_sec     <= ring_sec_nx;
            snooze_tmr   <= snooze_tmr_nx;
            beep_cnt     <= beep_cnt_nx;
            snooze_count <= snooze_count_nx;
            buzzer       <= buzzer_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        ring_sec_nx     = ring_sec;
        snooze_tmr_nx   = snooze_tmr;
        beep_cnt_nx     = beep_cnt;
        snooze_count_nx = snooze_count;
        buzzer_nx       = 1'b0;
        case (state)
            IDLE: begin
                if (alarm_rise) begin
                    state_nx    = RING;
                    ring_sec_nx = '0;
                    beep_cnt_nx = '0;
                    buzzer_nx   = 1'b1;
                end
            end
            RING: begin
                buzzer_nx = buzzer;
                if (beep_cnt == BEEP_LAST) begin
                    beep_cnt_nx = '0;
                    buzzer_nx   = ~buzzer;
                end else begin
                    beep_cnt_nx = beep_cnt + 26'd1;
                end
                if (sec_tick)
                    ring_sec_nx = ring_sec + 8'd1;
                // Dismiss outranks timeout, which outranks snooze.
                if (dismiss_rise || (sec_tick && ring_sec == RING_LAST)) begin
                    state_nx        = REARM;
                    snooze_count_nx = '0;
                    buzzer_nx       = 1'b0;
                end else if (snooze_rise && snooze_count < SNOOZE_MAX) begin
                    state_nx        = SNOOZE;
                    snooze_count_nx = snooze_count + 4'd1;
                    snooze_tmr_nx   = SNOOZE_LOAD;
                    buzzer_nx       = 1'b0;
                end
            end
            SNOOZE: begin
                if (dismiss_rise) begin
                    state_nx        = REARM;
                    snooze_count_nx = '0;
                end else if (sec_tick) begin
                    if (snooze_tmr == 10'd1) begin
                        state_nx    = RING;
                        ring_sec_nx = '0;
                        beep_cnt_nx = '0;
                        buzzer_nx   = 1'b1;
                    end else begin
                        snooze_tmr_nx = snooze_tmr - 10'd1;
                    end
                end
            end
            REARM: begin
                // Hold enable low past a second boundary so the same match can't re-latch.
                if (sec_tick)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: fixed vector table, hand-written corner sequences,
// and random stimulus checked against a behavioural model.
module tb_alarm_ringer;
    localparam int BH = 4;
    localparam int RT = 5;
    localparam int SS = 3;
    localparam int MS = 2;

    logic       clk = 1'b0;
    logic       reset, alarm_in, sec_tick, snooze_btn, dismiss_btn;
    logic       alarm_en_out, buzzer, ringing, snoozing;
    logic [3:0] snooze_count;
    logic [7:0] dut_out;

    alarm_ringer #(.BEEP_HALF(BH), .RING_TIMEOUT(RT), .SNOOZE_SEC(SS), .MAX_SNOOZE(MS)) dut (
        .clk(clk), .reset(reset), .alarm_in(alarm_in), .sec_tick(sec_tick),
        .snooze_btn(snooze_btn), .dismiss_btn(dismiss_btn),
        .alarm_en_out(alarm_en_out), .buzzer(buzzer), .ringing(ringing),
        .snoozing(snoozing), .snooze_count(snooze_count)
    );

    always #5 clk = ~clk;

    // Packed view: {alarm_en_out, buzzer, ringing, snoozing, snooze_count}
    assign dut_out = {alarm_en_out, buzzer, ringing, snoozing, snooze_count};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 ring, 2 snooze, 3 rearm.
    // Buzzer phase is derived arithmetically from the clocks elapsed since ringing began.
    int m_mode, m_n, m_start, m_ticks, m_left, m_cnt;
    bit m_pa, m_ps, m_pd;

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_ticks = 0; m_left = 0;
        m_pa = 0; m_ps = 0; m_pd = 0;
    endtask

    task automatic model_edge(input bit a, input bit t, input bit s, input bit d);
        bit ra, rs, rd;
        m_n++;
        ra = a & ~m_pa; rs = s & ~m_ps; rd = d & ~m_pd;
        case (m_mode)
            0: if (ra) begin m_mode = 1; m_start = m_n; m_ticks = 0; end
            1: begin
                if (rd || (t && m_ticks + 1 == RT)) begin m_mode = 3; m_cnt = 0; end
                else if (rs && m_cnt < MS) begin m_mode = 2; m_cnt++; m_left = SS; end
                else if (t) m_ticks++;
            end
            2: begin
                if (rd) begin m_mode = 3; m_cnt = 0; end
                else if (t) begin
                    if (m_left == 1) begin m_mode = 1; m_start = m_n; m_ticks = 0; end
                    else m_left--;
                end
            end
            default: if (t) m_mode = 0;
        endcase
        m_pa = a; m_ps = s; m_pd = d;
    endtask

    function automatic logic [7:0] model_out();
        logic bz;
        bz = (m_mode == 1) && ((((m_n - m_start) / BH) % 2) == 0);
        return {m_mode != 3, bz, m_mode == 1, m_mode == 2, 4'(m_cnt)};
    endfunction

    task automatic step(input logic a, input logic t, input logic s, input logic d);
        @(negedge clk);
        alarm_in = a; sec_tick = t; snooze_btn = s; dismiss_btn = d;
        @(posedge clk);
        model_edge(a, t, s, d);
        #1;
        chk("model", dut_out, model_out());
    endtask

    typedef struct {
        logic       a, t, s, d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[22];

    initial begin
        // Basic ring pattern, auto-dismiss timeout, then dismiss/snooze same-clk priority.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h80};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hE0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hE0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hE0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hE0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hE0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hE0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hE0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hE0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h80};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h80};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hE0};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h80};

        reset = 1'b0; alarm_in = 0; sec_tick = 0; snooze_btn = 0; dismiss_btn = 0;
        m_n = 0; m_start = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk("reset_state", dut_out, 8'h80);
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].a, tbl[i].t, tbl[i].s, tbl[i].d);
            chk($sformatf("vec%0d", i), dut_out, tbl[i].exp);
        end

        // Snooze limit: two snoozes allowed, third ignored.
        step(1, 0, 0, 0); chk("ring_start", dut_out, 8'hE0);
        step(1, 0, 1, 0); chk("snooze1", dut_out, 8'h91);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0); step(1, 1, 0, 0); chk("snooze1_hold", dut_out, 8'h91);
        step(1, 1, 0, 0); chk("rering1", dut_out, 8'hE1);
        step(1, 0, 1, 0); chk("snooze2", dut_out, 8'h92);
        step(1, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        chk("rering2", dut_out, 8'hE2);
        step(1, 0, 1, 0); chk("snooze_limit", dut_out, 8'hE2);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1); chk("dismiss_ring", dut_out, 8'h00);
        step(0, 1, 0, 0); chk("rearm_exit", dut_out, 8'h80);

        // Dismiss during snooze; alarm_in held high through REARM must not re-ring.
        step(1, 0, 0, 0);
        step(1, 0, 1, 0); chk("snz_entry", dut_out, 8'h91);
        step(1, 0, 0, 1); chk("snz_dismiss", dut_out, 8'h00);
        step(1, 0, 0, 0); chk("rearm_hold", dut_out, 8'h00);
        step(1, 1, 0, 0); chk("rearm_idle", dut_out, 8'h80);
        step(1, 0, 0, 0); chk("no_relatch1", dut_out, 8'h80);
        step(0, 0, 0, 0); chk("no_relatch2", dut_out, 8'h80);

        // Async reset mid-RING with buzzer high and a snooze already used.
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        chk("pre_reset", dut_out, 8'hE1);
        @(negedge clk);
        reset = 1'b0; alarm_in = 0; sec_tick = 0; snooze_btn = 0; dismiss_btn = 0;
        #1 chk("async_reset", dut_out, 8'h80);
        model_reset();
        @(negedge clk) reset = 1'b1;
        step(0, 0, 0, 0); chk("post_reset", dut_out, 8'h80);

        // Random stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            logic a, t, s, d;
            a = ($urandom_range(0, 9) == 0) ? ~alarm_in : alarm_in;
            t = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 5) == 0) ? ~snooze_btn : snooze_btn;
            d = ($urandom_range(0, 11) == 0) ? ~dismiss_btn : dismiss_btn;
            step(a, t, s, d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
